// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register busy scoreboard.
//
// NUM registers of WIDTH bits, NRD combinational read ports and NWR write
// ports. Writes land at the rising edge and are visible on the read ports in
// the same cycle through a bypass. Each register carries a busy bit: issue
// reserves it, writeback releases it, flush squashes every reservation.
//
// Conflict resolution is "highest write port index wins" everywhere, for
// storage and for bypass alike, so a reader never sees a value that will not
// be the one stored.
//
// Addresses are decoded by comparing against every legal register index, so
// an address >= NUM simply matches nothing. Such writes and issues fall away
// and such reads return zero and not busy.

module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int NUM      = 64,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*WIDTH-1:0]   rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*AW-1:0]      wr_addr,
    input  logic [NWR*WIDTH-1:0]   wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [NUM-1:0]         busy_vec
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs [NUM];
    logic [NUM-1:0]   busy_q;

    // ------------------------------------------------------------------
    // Per-register view of this cycle's writes
    // ------------------------------------------------------------------
    // wr_hit[i] : some active write port targets register i this cycle
    // wr_val[i] : the winning (highest-index) port's data for register i
    logic [NUM-1:0]   wr_hit;
    logic [WIDTH-1:0] wr_val [NUM];
    logic [NUM-1:0]   busy_d;

    // Resolve every write port onto the register it targets; later ports override earlier ones.
    always_comb begin
        // NOTE: every variable assigned in this block gets a default first,
        // so no path leaves it holding its old value and no latch is inferred.
        wr_hit = '0;
        for (int i = 0; i < NUM; i++) begin
            wr_val[i] = '0;
        end

        for (int i = 0; i < NUM; i++) begin
            // Ascending port order: the last match is the highest-index port.
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wr_data[w*WIDTH +: WIDTH];
                end
            end
        end

        // Register 0 is constant when hardwired, so it never accepts data.
        if (ZERO_REG != 0) begin
            wr_hit[0] = 1'b0;
            wr_val[0] = '0;
        end

        // While reset is held nothing may leak through the bypass either.
        if (!rstn) begin
            wr_hit = '0;
        end
    end

    // Next busy bits: flush beats reservation, reservation beats release.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Register storage: clear on reset, otherwise take the resolved write data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the array is reset element by element because reads of any
            // address must return zero straight out of reset; a RAM macro
            // without reset would not satisfy that.
            for (int i = 0; i < NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (wr_hit[i]) begin
                    // NOTE: state is updated with non-blocking assignments so
                    // every flop samples pre-edge values, independent of the
                    // order in which the always blocks are evaluated.
                    regs[i] <= wr_val[i];
                end
            end
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Read mux: bypass the winning same-cycle write, else the stored value.
    // A bypassed register is being supplied right now, so it is not busy.
    // An iss_en in the same cycle only shows up once busy_q has updated.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int i = 0; i < NUM; i++) begin
                if (rd_addr[p*AW +: AW] == AW'(i)) begin
                    rd_data[p*WIDTH +: WIDTH] = wr_hit[i] ? wr_val[i] : regs[i];
                    rd_busy[p]                = busy_q[i] & ~wr_hit[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb at default
// sizing (WIDTH=32, NUM=64, NRD=3, NWR=2, ZERO_REG=1). Inputs change on the
// falling edge; combinational outputs are sampled 1 time unit later, and
// registered state is sampled in the cycle following the edge that set it.

module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int NUM   = 64;
    localparam int NRD   = 3;
    localparam int NWR   = 2;
    localparam int AW    = 6;

    logic                 clk;
    logic                 rstn;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*WIDTH-1:0] wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 flush;
    logic [NUM-1:0]       busy_vec;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_sb #(
        .WIDTH(WIDTH), .NUM(NUM), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_vec(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no checking here) ----------------
    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        wr_en[w]               = 1'b1;
        wr_addr[w*AW +: AW]    = a;
        wr_data[w*WIDTH +: WIDTH] = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_en   = 1'b1;
        iss_addr = a;
    endtask

    function automatic logic [WIDTH-1:0] rdp(input int p);
        return rd_data[p*WIDTH +: WIDTH];
    endfunction

    // Move to the next falling edge (inputs change here).
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // ------------------------------ tests --------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        idle();
        set_wr(0, 6'd5, 32'h5555_5555);
        set_wr(1, 6'd6, 32'h6666_6666);
        issue(6'd5);
        set_rd(0, 6'd5);
        set_rd(1, 6'd6);
        set_rd(2, 6'd7);
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NRD; p++) begin
            tests_run++;
            if (rdp(p) !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_rd_data[%0d]: got %h want 00000000", p, rdp(p));
            end
        end
        tests_run++;
        if (rd_busy !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_rd_busy: got %b want 000", rd_busy);
        end
        tests_run++;
        if (busy_vec !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_busy_vec: got %h want 0", busy_vec);
        end
        next_cycle();
        rstn = 1'b1;
        idle();
        next_cycle();
        #1;
        tests_run++;
        if (rdp(0) !== 32'h0) begin
            tests_failed++;
            $display("FAIL post_reset_r5: got %h want 00000000", rdp(0));
        end
        tests_run++;
        if (busy_vec !== 64'h0) begin
            tests_failed++;
            $display("FAIL post_reset_busy_vec: got %h want 0", busy_vec);
        end
    endtask

    task automatic test_write_bypass();
        next_cycle();
        idle();
        set_wr(0, 6'd3, 32'hDEAD_BEEF);
        set_rd(0, 6'd3);
        #1;
        tests_run++;
        if (rdp(0) !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL bypass_r3: got %h want deadbeef", rdp(0));
        end
        next_cycle();
        idle();
        #1;
        tests_run++;
        if (rdp(0) !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL stored_r3: got %h want deadbeef", rdp(0));
        end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        idle();
        set_wr(1, 6'd0, 32'h1234_5678);
        issue(6'd0);
        set_rd(1, 6'd0);
        #1;
        tests_run++;
        if (rdp(1) !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_bypass: got %h want 00000000", rdp(1));
        end
        next_cycle();
        idle();
        #1;
        tests_run++;
        if (rdp(1) !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_stored: got %h want 00000000", rdp(1));
        end
        tests_run++;
        if (busy_vec[0] !== 1'b0 || rd_busy[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_busy: got busy_vec[0]=%b rd_busy=%b want 0/0", busy_vec[0], rd_busy[1]);
        end
    endtask

    task automatic test_conflict();
        next_cycle();
        idle();
        set_wr(0, 6'd7, 32'h1);
        set_wr(1, 6'd7, 32'h2);
        set_rd(2, 6'd7);
        #1;
        tests_run++;
        if (rdp(2) !== 32'h2) begin
            tests_failed++;
            $display("FAIL conflict_bypass: got %h want 00000002", rdp(2));
        end
        next_cycle();
        idle();
        #1;
        tests_run++;
        if (rdp(2) !== 32'h2) begin
            tests_failed++;
            $display("FAIL conflict_stored: got %h want 00000002", rdp(2));
        end
    endtask

    task automatic test_scoreboard();
        next_cycle();
        idle();
        issue(6'd9);
        set_rd(0, 6'd9);
        #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL iss_same_cycle_busy: got %b want 0", rd_busy[0]);
        end
        next_cycle();
        idle();
        #1;
        tests_run++;
        if (rd_busy[0] !== 1'b1 || busy_vec[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL iss_busy_r9: got rd_busy=%b busy_vec[9]=%b want 1/1", rd_busy[0], busy_vec[9]);
        end
        next_cycle();
        set_wr(1, 6'd9, 32'hAA);
        #1;
        tests_run++;
        if (rd_busy[0] !== 1'b0 || rdp(0) !== 32'hAA) begin
            tests_failed++;
            $display("FAIL wb_bypass_r9: got busy=%b data=%h want 0/000000aa", rd_busy[0], rdp(0));
        end
        tests_run++;
        if (busy_vec[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wb_busy_vec_lag: got %b want 1", busy_vec[9]);
        end
        next_cycle();
        idle();
        #1;
        tests_run++;
        if (busy_vec[9] !== 1'b0) begin
            tests_failed++;
            $display("FAIL wb_release_r9: got %b want 0", busy_vec[9]);
        end
        // Issue and write the same register together: reservation wins.
        next_cycle();
        issue(6'd9);
        set_wr(0, 6'd9, 32'h77);
        next_cycle();
        idle();
        #1;
        tests_run++;
        if (busy_vec[9] !== 1'b1 || rd_busy[0] !== 1'b1 || rdp(0) !== 32'h77) begin
            tests_failed++;
            $display("FAIL iss_wr_same_r9: got busy_vec=%b rd_busy=%b data=%h want 1/1/00000077",
                     busy_vec[9], rd_busy[0], rdp(0));
        end
        // Release r9 so the flush test starts from a known scoreboard.
        next_cycle();
        set_wr(0, 6'd9, 32'h99);
        next_cycle();
        idle();
    endtask

    task automatic test_flush();
        logic [NUM-1:0] exp_busy;
        next_cycle();
        set_wr(0, 6'd4, 32'h44);
        set_wr(1, 6'd10, 32'h1010);
        next_cycle();
        idle();
        issue(6'd4);
        next_cycle();
        issue(6'd10);
        next_cycle();
        issue(6'd33);
        next_cycle();
        idle();
        #1;
        exp_busy = '0;
        exp_busy[4]  = 1'b1;
        exp_busy[10] = 1'b1;
        exp_busy[33] = 1'b1;
        tests_run++;
        if (busy_vec !== exp_busy) begin
            tests_failed++;
            $display("FAIL reserve_busy_vec: got %h want %h", busy_vec, exp_busy);
        end
        flush = 1'b1;
        issue(6'd11);
        next_cycle();
        idle();
        set_rd(0, 6'd4);
        set_rd(1, 6'd10);
        set_rd(2, 6'd3);
        #1;
        tests_run++;
        if (busy_vec !== 64'h0) begin
            tests_failed++;
            $display("FAIL flush_busy_vec: got %h want 0", busy_vec);
        end
        tests_run++;
        if (rdp(0) !== 32'h44 || rdp(1) !== 32'h1010 || rdp(2) !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL flush_contents: got %h %h %h want 00000044 00001010 deadbeef",
                     rdp(0), rdp(1), rdp(2));
        end
    endtask

    task automatic test_async_reset();
        next_cycle();
        issue(6'd20);
        next_cycle();
        idle();
        set_rd(0, 6'd3);
        #2;
        rstn = 1'b0;     // between edges: must act without a clock
        #1;
        tests_run++;
        if (rdp(0) !== 32'h0 || busy_vec !== 64'h0) begin
            tests_failed++;
            $display("FAIL async_reset: got data=%h busy_vec=%h want 0/0", rdp(0), busy_vec);
        end
        next_cycle();
        rstn = 1'b1;
    endtask

    initial begin
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_addr = '0;
        idle();
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
